cluster_periph_router: RTL and testbench

// - Master-side counterpart of the cluster peripheral slave map: takes one core-side periph request port
//   and routes each request to one of NB_SPERIPHS slave ports (EOC=0, TIMER=1, EVENT_U=2, HWPE=4, ICACHE_CTRL=5,
//   DMA_CL=6, DMA_FC=7, JPEG=8, EXT=9).
// - Tracks outstanding transactions and returns responses in order.
// - Unmapped slots (3, 10..15) are answered by an internal error responder.
// - Sits between each core's periph demux and the periph interconnect slave side.

---
 rtl/cluster_periph_router_pkg.sv | 29 ++
 rtl/cluster_periph_order_fifo.sv | 68 ++++++
 rtl/cluster_periph_router.sv | 123 ++++++++++++
 tb/tb_cluster_periph_router.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cluster_periph_router_pkg.sv
// Shared slot map and tag constants for the cluster peripheral request router.
package cluster_periph_router_pkg;

  localparam int NB_SPERIPHS = 10;

  localparam int SPER_EOC_ID         = 0;
  localparam int SPER_TIMER_ID       = 1;
  localparam int SPER_EVENT_U_ID     = 2;
  localparam int SPER_RSVD_ID        = 3;
  localparam int SPER_HWPE_ID        = 4;
  localparam int SPER_ICACHE_CTRL_ID = 5;
  localparam int SPER_DMA_CL_ID      = 6;
  localparam int SPER_DMA_FC_ID      = 7;
  localparam int SPER_JPEG_ID        = 8;
  localparam int SPER_EXT_ID         = 9;

  localparam int SPER_IDX_LSB = 10;
  localparam int SPER_IDX_W   = 4;

  typedef logic [SPER_IDX_W-1:0] sper_idx_t;

  localparam sper_idx_t ERR_TAG = 4'hF;

  // Slot 3 and everything past the last slave fall to the error responder.
  function automatic logic is_mapped(input sper_idx_t idx);
    return (32'(idx) < NB_SPERIPHS) && (32'(idx) != SPER_RSVD_ID);
  endfunction

endpackage

// File: rtl/cluster_periph_order_fifo.sv
// In-flight tag FIFO: remembers which slave (or the error responder) owes each response, in issue order.
module cluster_periph_order_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic                   pop_i,
  output logic [TAG_W-1:0]       head_o,
  output logic [TAG_W-1:0]       head_nxt_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   empty_nxt_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [PTR_W:0]   count, count_nxt;
  logic             do_push, do_pop;

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign do_pop     = pop_i && (count != '0);
  // DEPTH is a power of two, so the count MSB alone flags full; a same-cycle pop frees a slot.
  assign do_push    = push_i && (!count[PTR_W] || do_pop);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // The pushed tag becomes the next head only when it will be the sole entry.
  always_comb begin
    head_nxt_o = do_pop ? mem[rd_ptr_inc] : mem[rd_ptr];
    if (do_push && (count_nxt == (PTR_W+1)'(1))) head_nxt_o = tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= tag_i;
  end

  assign head_o      = mem[rd_ptr];
  assign full_o      = count[PTR_W];
  assign empty_o     = (count == '0);
  assign empty_nxt_o = (count_nxt == '0);
  assign count_o     = count;

endmodule

// File: rtl/cluster_periph_router.sv
// Routes one core-side periph request port to the cluster peripheral slaves, returning responses in order.
module cluster_periph_router
  import cluster_periph_router_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              m_req_i,
  output logic                              m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]             m_add_i,
  input  logic                              m_wen_i,
  input  logic [DATA_WIDTH/8-1:0]           m_be_i,
  input  logic [DATA_WIDTH-1:0]             m_wdata_i,
  output logic                              m_r_valid_o,
  output logic [DATA_WIDTH-1:0]             m_r_rdata_o,
  output logic                              m_r_opc_o,
  output logic [NB_SPERIPHS-1:0]            s_req_o,
  input  logic [NB_SPERIPHS-1:0]            s_gnt_i,
  output logic [ADDR_WIDTH-1:0]             s_add_o,
  output logic                              s_wen_o,
  output logic [DATA_WIDTH/8-1:0]           s_be_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic [NB_SPERIPHS-1:0]            s_r_valid_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0] s_r_rdata_i,
  input  logic [NB_SPERIPHS-1:0]            s_r_opc_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  sper_idx_t              req_idx, last_idx, push_tag, head_tag, head_nxt;
  logic                   req_mapped, order_block, full_eff, fwd;
  logic                   push, pop, head_rsp_vld, err_pending;
  logic                   fifo_full, fifo_empty, fifo_empty_nxt;
  logic [CNT_W-1:0]       count;
  logic [NB_SPERIPHS-1:0] head_oh;

  assign req_idx    = m_add_i[SPER_IDX_LSB +: SPER_IDX_W];
  assign req_mapped = is_mapped(req_idx);
  assign push_tag   = req_mapped ? req_idx : ERR_TAG;

  always_comb begin
    head_oh = '0;
    if (!fifo_empty && (head_tag != ERR_TAG)) head_oh = NB_SPERIPHS'(1) << head_tag;
  end

  assign head_rsp_vld = |(s_r_valid_i & head_oh);
  assign pop          = err_pending || head_rsp_vld;

  // Requests stay on one target while anything is in flight so responses cannot overtake each other.
  assign order_block = (count != '0) && (req_idx != last_idx);
  assign full_eff    = fifo_full && !pop;
  assign fwd         = m_req_i && !full_eff && !order_block;

  always_comb begin
    s_req_o = '0;
    if (fwd && req_mapped) s_req_o = NB_SPERIPHS'(1) << req_idx;
  end

  assign m_gnt_o = req_mapped ? |(s_req_o & s_gnt_i) : fwd;
  assign push    = m_gnt_o;

  assign s_add_o   = m_add_i;
  assign s_wen_o   = m_wen_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  cluster_periph_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .TAG_W (SPER_IDX_W)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .tag_i       (push_tag),
    .pop_i       (pop),
    .head_o      (head_tag),
    .head_nxt_o  (head_nxt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt),
    .count_o     (count)
  );

  // err_pending is high exactly while an ERR tag sits at the FIFO head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pending <= 1'b0;
      last_idx    <= '0;
    end else begin
      err_pending <= !fifo_empty_nxt && (head_nxt == ERR_TAG);
      if (push) last_idx <= req_idx;
    end
  end

  always_comb begin
    m_r_rdata_o = '0;
    m_r_opc_o   = 1'b0;
    if (err_pending) begin
      m_r_rdata_o = DATA_WIDTH'(ERR_RDATA);
      m_r_opc_o   = 1'b1;
    end else begin
      for (int i = 0; i < NB_SPERIPHS; i++) begin
        if (head_oh[i] && s_r_valid_i[i]) begin
          m_r_rdata_o = s_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
          m_r_opc_o   = s_r_opc_i[i];
        end
      end
    end
  end

  assign m_r_valid_o = pop;

  always_ff @(posedge clk_i) begin
    if (!rst_i && !fifo_empty)
      assert ((s_r_valid_i & ~head_oh) == '0)
        else $error("response valid from a slave that is not at the order FIFO head");
  end

endmodule

// File: tb/tb_cluster_periph_router.sv
// Bench for cluster_periph_router: directed scenarios plus random traffic against a queue-based reference.
module tb_cluster_periph_router;
  import cluster_periph_router_pkg::*;

  localparam int NB   = NB_SPERIPHS;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXO = 4;
  localparam logic [31:0] ERR_RD = 32'hBADACCE5;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_req, m_gnt, m_wen, m_r_valid, m_r_opc, s_wen;
  logic [AW-1:0]     m_add, s_add;
  logic [DW/8-1:0]   m_be, s_be;
  logic [DW-1:0]     m_wdata, s_wdata, m_r_rdata;
  logic [NB-1:0]     s_req, s_gnt, s_r_valid, s_r_opc;
  logic [NB*DW-1:0]  s_r_rdata;

  always #5 clk = ~clk;

  cluster_periph_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .ERR_RDATA(ERR_RD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_add_i(m_add), .m_wen_i(m_wen), .m_be_i(m_be),
    .m_wdata_i(m_wdata), .m_r_valid_o(m_r_valid), .m_r_rdata_o(m_r_rdata), .m_r_opc_o(m_r_opc),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_add_o(s_add), .s_wen_o(s_wen), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata), .s_r_opc_i(s_r_opc)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: tags owed in order (15 = error responder) and the last accepted slot index.
  int q[$];
  int last_idx = 0;

  logic          obs_gnt, obs_vld, obs_opc;
  logic [31:0]   obs_rd;
  logic [NB-1:0] obs_sreq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NB*DW-1:0] one_rd(input int slot, input logic [31:0] d);
    logic [NB*DW-1:0] v;
    v = '0;
    v[slot*DW +: DW] = d;
    return v;
  endfunction

  function automatic logic [NB-1:0] bit_of(input int slot);
    logic [NB-1:0] v;
    v = '0;
    v[slot] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    m_req     = 1'b0;
    s_r_valid = '0;
    q.delete();
  endtask

  // One clock: drive at negedge, check against the reference, then advance the reference.
  task automatic cycle(input logic req, input int idx, input logic wen,
                       input logic [NB-1:0] sgnt, input logic [NB-1:0] svld,
                       input logic [NB*DW-1:0] rdata, input logic [NB-1:0] sopc);
    logic [31:0]   a, e_rd;
    logic          e_vld, e_opc, e_gnt, mapped, fwd, blocked, full;
    logic [NB-1:0] e_sreq;
    @(negedge clk);
    a = $urandom;
    a[13:10] = 4'(idx);
    rst = 1'b0; m_req = req; m_add = a; m_wen = wen; m_be = 4'($urandom); m_wdata = $urandom;
    s_gnt = sgnt; s_r_valid = svld; s_r_rdata = rdata; s_r_opc = sopc;
    #1;
    e_vld = 1'b0; e_rd = '0; e_opc = 1'b0;
    if (q.size() != 0) begin
      if (q[0] == 15) begin
        e_vld = 1'b1; e_rd = ERR_RD; e_opc = 1'b1;
      end else if (svld[q[0]]) begin
        e_vld = 1'b1; e_rd = rdata[q[0]*DW +: DW]; e_opc = sopc[q[0]];
      end
    end
    mapped  = (idx < NB) && (idx != 3);
    full    = (q.size() == MAXO) && !e_vld;
    blocked = (q.size() != 0) && (idx != last_idx);
    fwd     = req && !full && !blocked;
    e_sreq  = (fwd && mapped) ? bit_of(idx) : '0;
    e_gnt   = fwd && (mapped ? sgnt[idx] : 1'b1);
    chk("m_gnt", m_gnt, e_gnt);
    chk("s_req", s_req, e_sreq);
    chk("m_r_valid", m_r_valid, e_vld);
    chk("s_add", s_add, a);
    if (e_vld) begin
      chk("m_r_rdata", m_r_rdata, e_rd);
      chk("m_r_opc", m_r_opc, e_opc);
    end
    obs_gnt = m_gnt; obs_vld = m_r_valid; obs_rd = m_r_rdata; obs_opc = m_r_opc; obs_sreq = s_req;
    if (e_vld) void'(q.pop_front());
    if (e_gnt) begin
      q.push_back(mapped ? idx : 15);
      last_idx = idx;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0]    sg, sv, so;
    logic [NB*DW-1:0] rd;
    logic             rq;
    int               ix;
    rst = 1'b1; m_req = 1'b0; m_add = '0; m_wen = 1'b0; m_be = '0; m_wdata = '0;
    s_gnt = '0; s_r_valid = '0; s_r_rdata = '0; s_r_opc = '0;
    do_reset();
    do_reset();

    // Reset state
    cycle(1'b0, 0, 1'b1, '0, '0, '0, '0);
    chk("rst_gnt", obs_gnt, 0); chk("rst_vld", obs_vld, 0);
    chk("rst_rdata", obs_rd, 0); chk("rst_opc", obs_opc, 0); chk("rst_sreq", obs_sreq, 0);

    // TIMER read, response two cycles later
    cycle(1'b1, SPER_TIMER_ID, 1'b1, bit_of(1), '0, '0, '0);
    chk("timer_gnt", obs_gnt, 1); chk("timer_sreq", obs_sreq, 10'h002);
    cycle(1'b0, 0, 1'b1, '0, '0, '0, '0);
    chk("timer_wait_vld", obs_vld, 0);
    cycle(1'b0, 0, 1'b1, '0, bit_of(1), one_rd(1, 32'h1234), '0);
    chk("timer_vld", obs_vld, 1); chk("timer_rdata", obs_rd, 32'h1234); chk("timer_opc", obs_opc, 0);

    // Write to reserved slot 3
    cycle(1'b1, 3, 1'b0, '1, '0, '0, '0);
    chk("err_gnt", obs_gnt, 1); chk("err_sreq", obs_sreq, 0);
    cycle(1'b0, 0, 1'b1, '0, '0, '0, '0);
    chk("err_vld", obs_vld, 1); chk("err_rdata", obs_rd, 32'hBADACCE5); chk("err_opc", obs_opc, 1);

    // DMA_CL fill to capacity, then pop-and-push at full
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, SPER_DMA_CL_ID, 1'b1, bit_of(6), '0, '0, '0);
      chk("dma_fill_gnt", obs_gnt, 1);
    end
    cycle(1'b1, SPER_DMA_CL_ID, 1'b1, bit_of(6), '0, '0, '0);
    chk("dma_full_gnt", obs_gnt, 0); chk("dma_full_sreq", obs_sreq, 0);
    cycle(1'b1, SPER_DMA_CL_ID, 1'b1, bit_of(6), bit_of(6), one_rd(6, 32'hD0D0), '0);
    chk("dma_free_vld", obs_vld, 1); chk("dma_free_gnt", obs_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 0, 1'b1, '0, bit_of(6), one_rd(6, 32'hD000 + 32'(i)), '0);
      chk("dma_drain_vld", obs_vld, 1);
    end

    // EVENT_U outstanding holds a HWPE request until it pops
    cycle(1'b1, SPER_EVENT_U_ID, 1'b1, bit_of(2), '0, '0, '0);
    chk("evu_gnt", obs_gnt, 1);
    cycle(1'b1, SPER_HWPE_ID, 1'b1, bit_of(4), '0, '0, '0);
    chk("hwpe_hold_sreq", obs_sreq, 0); chk("hwpe_hold_gnt", obs_gnt, 0);
    cycle(1'b1, SPER_HWPE_ID, 1'b1, bit_of(4), bit_of(2), one_rd(2, 32'hE7E7), '0);
    chk("evu_vld", obs_vld, 1); chk("hwpe_pop_gnt", obs_gnt, 0);
    cycle(1'b1, SPER_HWPE_ID, 1'b1, bit_of(4), '0, '0, '0);
    chk("hwpe_gnt", obs_gnt, 1); chk("hwpe_sreq", obs_sreq, 10'h010);
    cycle(1'b0, 0, 1'b1, '0, bit_of(4), one_rd(4, 32'h4444), bit_of(4));
    chk("hwpe_vld", obs_vld, 1); chk("hwpe_opc", obs_opc, 1);

    // Reset with two outstanding, stale response afterwards, then a clean EOC access
    cycle(1'b1, SPER_TIMER_ID, 1'b1, bit_of(1), '0, '0, '0);
    cycle(1'b1, SPER_TIMER_ID, 1'b1, bit_of(1), '0, '0, '0);
    chk("pre_rst_gnt", obs_gnt, 1);
    do_reset();
    cycle(1'b0, 0, 1'b1, '0, bit_of(1), one_rd(1, 32'hDEAD), '0);
    chk("stale_vld", obs_vld, 0);
    cycle(1'b1, SPER_EOC_ID, 1'b1, bit_of(0), '0, '0, '0);
    chk("eoc_gnt", obs_gnt, 1); chk("eoc_sreq", obs_sreq, 10'h001);
    cycle(1'b0, 0, 1'b1, '0, bit_of(0), one_rd(0, 32'h55), '0);
    chk("eoc_vld", obs_vld, 1); chk("eoc_rdata", obs_rd, 32'h55);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
        continue;
      end
      rq = ($urandom_range(3) != 0);
      ix = ($urandom_range(2) == 0) ? int'($urandom_range(15)) : last_idx;
      sg = NB'($urandom);
      for (int s = 0; s < NB; s++) rd[s*DW +: DW] = $urandom;
      sv = '0;
      so = '0;
      if (q.size() == 0) begin
        if ($urandom_range(3) == 0) sv = NB'($urandom);
      end else if (q[0] != 15 && $urandom_range(2) == 0) begin
        sv[q[0]] = 1'b1;
        so[q[0]] = ($urandom_range(7) == 0);
      end
      cycle(rq, ix, 1'($urandom), sg, sv, rd, so);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
